udp_echo_client_ctrl: RTL and testbench

Control block for a UDP echo client tile, the initiator paired with the echo responder app.
- Sends a configured number of UDP request messages onto noc0 (header flit, metadata flit, payload flits).
- Stop-and-wait: exactly one request in flight. Each request's echoed response must arrive before the next request is sent.
- Steers an external datapath through mux selects and store strobes, and keeps run statistics.

---
 rtl/udp_echo_client_ctrl_pkg.sv | 31 +++
 rtl/udp_echo_client_ctrl_rx_ctrl.sv | 112 +++++++++++
 rtl/udp_echo_client_ctrl.sv | 177 +++++++++++++++++
 tb/tb_udp_echo_client_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_echo_client_ctrl_pkg.sv
// Shared types for the UDP echo client control block.
//   mux_sel_e  : outbound datapath mux select (header / metadata / payload)
//   tx_state_e : transmit FSM states (top level)
//   rx_state_e : receive FSM states (udp_echo_client_rx_ctrl)
// NOC_DATA_BYTES_W is the byte-offset width of the default 64-byte flit.
package udp_echo_client_ctrl_pkg;

    localparam int NOC_DATA_BYTES_W = 6;

    typedef enum logic [1:0] {
        SEL_HDR  = 2'd0,
        SEL_META = 2'd1,
        SEL_DATA = 2'd2
    } mux_sel_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_META,
        TX_DATA,
        TX_WAIT
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HDR,
        RX_META,
        RX_DATA
    } rx_state_e;

endpackage

// File: rtl/udp_echo_client_ctrl_rx_ctrl.sv
// Receive side of the UDP echo client: accepts one echoed response
// (header, metadata, payload flits), strobes the datapath capture
// registers and keeps the response / mismatch statistics.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   clear_stats         : zero both statistics counters (run start)
//   arm                 : enter HDR and start accepting a response
//   abort               : return to IDLE immediately (timeout)
//   payload_flits       : payload flits per response
//   in_val / in_rdy     : inbound flit handshake (transfer on val && rdy)
//   in_data_match       : datapath compare result for current payload flit
//   store_hdr/store_meta: capture strobes, high on the matching transfer
//   in_flit_idx         : index of the current inbound payload flit
//   stat_resps_rcvd     : responses fully received (saturating)
//   stat_mismatches     : payload flits that failed comparison (saturating)
//   resp_done           : high on the transfer of the final response flit
//   mismatch_now        : high on a payload transfer that fails comparison
module udp_echo_client_rx_ctrl
    import udp_echo_client_ctrl_pkg::*;
#(
    parameter int REQ_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_stats,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [15:0]          payload_flits,
    input  logic                 in_val,
    input  logic                 in_data_match,
    output logic                 in_rdy,
    output logic                 store_hdr,
    output logic                 store_meta,
    output logic [15:0]          in_flit_idx,
    output logic [REQ_CNT_W-1:0] stat_resps_rcvd,
    output logic [REQ_CNT_W-1:0] stat_mismatches,
    output logic                 resp_done,
    output logic                 mismatch_now
);

    rx_state_e rx_state;
    logic      in_xfer;

    assign in_xfer      = in_val && in_rdy;
    // Strobes coincide with the transfer so the datapath captures the flit
    // that is on the bus in that cycle.
    assign store_hdr    = in_xfer && (rx_state == RX_HDR);
    assign store_meta   = in_xfer && (rx_state == RX_META);
    assign mismatch_now = in_xfer && (rx_state == RX_DATA) && !in_data_match;
    // Combinational so the TX side sees completion in the same cycle as a
    // possible timeout expiry and can let completion win.
    assign resp_done    = in_xfer &&
                          (((rx_state == RX_META) && (payload_flits == 16'd0)) ||
                           ((rx_state == RX_DATA) && (in_flit_idx == payload_flits - 16'd1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state        <= RX_IDLE;
            in_rdy          <= 1'b0;
            in_flit_idx     <= 16'd0;
            stat_resps_rcvd <= '0;
            stat_mismatches <= '0;
        end else begin
            if (clear_stats) begin
                stat_resps_rcvd <= '0;
                stat_mismatches <= '0;
            end else begin
                if (mismatch_now && (stat_mismatches != '1))
                    stat_mismatches <= stat_mismatches + REQ_CNT_W'(1);
                if (resp_done && (stat_resps_rcvd != '1))
                    stat_resps_rcvd <= stat_resps_rcvd + REQ_CNT_W'(1);
            end

            if (abort) begin
                rx_state    <= RX_IDLE;
                in_rdy      <= 1'b0;
                in_flit_idx <= 16'd0;
            end else begin
                case (rx_state)
                    RX_IDLE: if (arm) begin
                        rx_state <= RX_HDR;
                        in_rdy   <= 1'b1;
                    end
                    RX_HDR: if (in_xfer) rx_state <= RX_META;
                    RX_META: if (in_xfer) begin
                        if (payload_flits == 16'd0) begin
                            rx_state <= RX_IDLE;
                            in_rdy   <= 1'b0;
                        end else begin
                            rx_state    <= RX_DATA;
                            in_flit_idx <= 16'd0;
                        end
                    end
                    RX_DATA: if (in_xfer) begin
                        if (in_flit_idx == payload_flits - 16'd1) begin
                            rx_state    <= RX_IDLE;
                            in_rdy      <= 1'b0;
                            in_flit_idx <= 16'd0;
                        end else begin
                            in_flit_idx <= in_flit_idx + 16'd1;
                        end
                    end
                    default: begin
                        rx_state <= RX_IDLE;
                        in_rdy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/udp_echo_client_ctrl.sv
// UDP echo client control: sends cfg_num_reqs request messages
// (header, metadata, payload flits) stop-and-wait, checks each echoed
// response through udp_echo_client_rx_ctrl, and aborts the run if a
// response does not arrive within TIMEOUT_CYCLES.
// Ports:
//   start/cfg_*           : run request, config sampled at start
//   busy/done/done_err    : run status; done is a one-cycle pulse
//   client_out_noc0_vrtoc_val / noc0_vrtoc_client_out_rdy : outbound handshake
//   out_data_mux_sel/out_flit_idx : outbound datapath steering
//   noc0_ctovr_client_in_val / client_in_noc0_ctovr_rdy  : inbound handshake
//   in_store_hdr_flit/in_store_meta_flit/in_flit_idx/in_data_match : inbound datapath
//   stat_*                : saturating run statistics, cleared at start
// Handshake: a flit moves when val && rdy; val is held and the selects are
// frozen until that happens.
module udp_echo_client_ctrl
    import udp_echo_client_ctrl_pkg::*;
#(
    parameter int NOC_DATA_BYTES = 64,
    parameter int REQ_CNT_W      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [REQ_CNT_W-1:0] cfg_num_reqs,
    input  logic [15:0]          cfg_payload_bytes,
    output logic                 busy,
    output logic                 done,
    output logic                 done_err,
    output logic                 client_out_noc0_vrtoc_val,
    input  logic                 noc0_vrtoc_client_out_rdy,
    output logic [1:0]           out_data_mux_sel,
    output logic [15:0]          out_flit_idx,
    input  logic                 noc0_ctovr_client_in_val,
    output logic                 client_in_noc0_ctovr_rdy,
    output logic                 in_store_hdr_flit,
    output logic                 in_store_meta_flit,
    output logic [15:0]          in_flit_idx,
    input  logic                 in_data_match,
    output logic [REQ_CNT_W-1:0] stat_reqs_sent,
    output logic [REQ_CNT_W-1:0] stat_resps_rcvd,
    output logic [REQ_CNT_W-1:0] stat_mismatches
);

    localparam int                SHIFT    = $clog2(NOC_DATA_BYTES);
    localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

    tx_state_e            tx_state;
    logic [REQ_CNT_W-1:0] num_reqs;
    logic [15:0]          payload_flits;
    logic [TMR_W-1:0]     timer;
    logic [16:0]          bytes_round;
    logic                 out_xfer;
    logic                 last_out;
    logic                 clear_stats;
    logic                 rx_arm;
    logic                 rx_abort;
    logic                 resp_done;
    logic                 mismatch_now;

    // 17-bit sum so a payload near 64 KiB does not wrap before the divide.
    assign bytes_round = {1'b0, cfg_payload_bytes} + 17'(NOC_DATA_BYTES - 1);
    assign out_xfer    = client_out_noc0_vrtoc_val && noc0_vrtoc_client_out_rdy;
    assign last_out    = ((tx_state == TX_META) && (payload_flits == 16'd0)) ||
                         ((tx_state == TX_DATA) && (out_flit_idx == payload_flits - 16'd1));
    assign clear_stats = (tx_state == TX_IDLE) && start;
    // RX is armed on the same edge TX enters WAIT; with no payload that is
    // the metadata transfer itself.
    assign rx_arm      = out_xfer && last_out;
    assign rx_abort    = (tx_state == TX_WAIT) && (timer == TMR_W'(1)) && !resp_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state                  <= TX_IDLE;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            done_err                  <= 1'b0;
            client_out_noc0_vrtoc_val <= 1'b0;
            out_data_mux_sel          <= SEL_HDR;
            out_flit_idx              <= 16'd0;
            num_reqs                  <= '0;
            payload_flits             <= 16'd0;
            timer                     <= '0;
            stat_reqs_sent            <= '0;
        end else begin
            done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    // busy drops the cycle after done.
                    busy <= 1'b0;
                    if (start) begin
                        num_reqs       <= cfg_num_reqs;
                        payload_flits  <= 16'(bytes_round >> SHIFT);
                        stat_reqs_sent <= '0;
                        done_err       <= 1'b0;
                        if (cfg_num_reqs == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy                      <= 1'b1;
                            tx_state                  <= TX_HDR;
                            client_out_noc0_vrtoc_val <= 1'b1;
                            out_data_mux_sel          <= SEL_HDR;
                        end
                    end
                end
                TX_HDR: if (out_xfer) begin
                    tx_state         <= TX_META;
                    out_data_mux_sel <= SEL_META;
                end
                TX_META, TX_DATA: if (out_xfer) begin
                    if (last_out) begin
                        tx_state                  <= TX_WAIT;
                        client_out_noc0_vrtoc_val <= 1'b0;
                        out_data_mux_sel          <= SEL_HDR;
                        out_flit_idx              <= 16'd0;
                        timer                     <= TMR_LOAD;
                        if (stat_reqs_sent != '1)
                            stat_reqs_sent <= stat_reqs_sent + REQ_CNT_W'(1);
                    end else if (tx_state == TX_META) begin
                        tx_state         <= TX_DATA;
                        out_data_mux_sel <= SEL_DATA;
                        out_flit_idx     <= 16'd0;
                    end else begin
                        out_flit_idx <= out_flit_idx + 16'd1;
                    end
                end
                TX_WAIT: begin
                    // Completion is checked first so it wins over expiry.
                    if (resp_done) begin
                        if (stat_reqs_sent == num_reqs) begin
                            tx_state <= TX_IDLE;
                            done     <= 1'b1;
                            done_err <= (stat_mismatches != '0) || mismatch_now;
                        end else begin
                            tx_state                  <= TX_HDR;
                            client_out_noc0_vrtoc_val <= 1'b1;
                            out_data_mux_sel          <= SEL_HDR;
                        end
                    end else if (timer == TMR_W'(1)) begin
                        tx_state <= TX_IDLE;
                        done     <= 1'b1;
                        done_err <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    tx_state                  <= TX_IDLE;
                    client_out_noc0_vrtoc_val <= 1'b0;
                end
            endcase
        end
    end

    udp_echo_client_rx_ctrl #(
        .REQ_CNT_W(REQ_CNT_W)
    ) u_rx (
        .clk            (clk),
        .rst            (rst),
        .clear_stats    (clear_stats),
        .arm            (rx_arm),
        .abort          (rx_abort),
        .payload_flits  (payload_flits),
        .in_val         (noc0_ctovr_client_in_val),
        .in_data_match  (in_data_match),
        .in_rdy         (client_in_noc0_ctovr_rdy),
        .store_hdr      (in_store_hdr_flit),
        .store_meta     (in_store_meta_flit),
        .in_flit_idx    (in_flit_idx),
        .stat_resps_rcvd(stat_resps_rcvd),
        .stat_mismatches(stat_mismatches),
        .resp_done      (resp_done),
        .mismatch_now   (mismatch_now)
    );

endmodule

// File: tb/tb_udp_echo_client_ctrl.sv
// Directed bench for udp_echo_client_ctrl with a loopback responder:
// every completed outbound request is echoed back as the same number of
// inbound flits (unless responses are disabled for the timeout case).
module tb_udp_echo_client_ctrl;

    localparam int BUDGET = 600;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_num_reqs;
    logic [15:0] cfg_payload_bytes;
    logic        busy, done, done_err;
    logic        out_val;
    logic        out_rdy;
    logic [1:0]  out_sel;
    logic [15:0] out_idx;
    logic        in_val;
    logic        in_rdy;
    logic        store_hdr, store_meta;
    logic [15:0] in_idx;
    logic        in_match;
    logic [15:0] st_sent, st_rcvd, st_mism;

    udp_echo_client_ctrl #(
        .NOC_DATA_BYTES(64),
        .REQ_CNT_W     (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .cfg_num_reqs             (cfg_num_reqs),
        .cfg_payload_bytes        (cfg_payload_bytes),
        .busy                     (busy),
        .done                     (done),
        .done_err                 (done_err),
        .client_out_noc0_vrtoc_val(out_val),
        .noc0_vrtoc_client_out_rdy(out_rdy),
        .out_data_mux_sel         (out_sel),
        .out_flit_idx             (out_idx),
        .noc0_ctovr_client_in_val (in_val),
        .client_in_noc0_ctovr_rdy (in_rdy),
        .in_store_hdr_flit        (store_hdr),
        .in_store_meta_flit       (store_meta),
        .in_flit_idx              (in_idx),
        .in_data_match            (in_match),
        .stat_reqs_sent           (st_sent),
        .stat_resps_rcvd          (st_rcvd),
        .stat_mismatches          (st_mism)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard: observed and expected outbound {sel, idx}
    logic [17:0] obs_q[$];
    logic [17:0] exp_q[$];

    int n_out, n_in, n_store_hdr, n_store_meta;
    int stall_err, order_err, strobe_err;
    int got_done, done_err_seen, done_cycle, last_out_cyc, busy_ever;
    int busy_after, done_after;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int nreq, input int nbytes);
        cfg_num_reqs      = 16'(nreq);
        cfg_payload_bytes = 16'(nbytes);
        start             = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one full run from the current negedge. rdy_toggle alternates
    // outbound ready; mm_req/mm_idx select a payload flit to mis-compare.
    task automatic do_run(input int nreq, input int nbytes, input bit rdy_toggle,
                          input bit respond, input int mm_req, input int mm_idx);
        int flits, out_pos, in_pos, pending, resp_idx, cyc;
        bit prev_stall;
        logic [1:0] prev_sel;
        logic [15:0] prev_idx;
        flits = 2 + (nbytes + 63) / 64;
        out_pos = 0; in_pos = 0; pending = 0; resp_idx = 0; cyc = 0;
        prev_stall = 1'b0; prev_sel = 2'd0; prev_idx = 16'd0;
        obs_q.delete();
        n_out = 0; n_in = 0; n_store_hdr = 0; n_store_meta = 0;
        stall_err = 0; order_err = 0; strobe_err = 0;
        got_done = 0; done_err_seen = 0; done_cycle = -1; last_out_cyc = -1; busy_ever = 0;
        pulse_start(nreq, nbytes);
        while (got_done == 0 && cyc < BUDGET) begin
            out_rdy  = rdy_toggle ? ((cyc % 2) == 1) : 1'b1;
            in_val   = (pending > 0);
            in_match = !((resp_idx == mm_req) && (in_pos == 2 + mm_idx));
            #1;
            if (busy) busy_ever = 1;
            if (prev_stall && (!out_val || out_sel != prev_sel || out_idx != prev_idx))
                stall_err++;
            prev_stall = out_val && !out_rdy;
            prev_sel   = out_sel;
            prev_idx   = out_idx;
            if (out_val && out_rdy) begin
                obs_q.push_back({out_sel, (out_sel == 2'd2) ? out_idx : 16'd0});
                n_out++;
                if (out_sel == 2'd0 && (pending > 0 || in_pos != 0)) order_err++;
                out_pos++;
                if (out_pos == flits) begin
                    out_pos = 0;
                    last_out_cyc = cyc;
                    if (respond) pending = flits;
                end
            end
            if (in_val && in_rdy) begin
                if (store_hdr != (in_pos == 0)) strobe_err++;
                if (store_meta != (in_pos == 1)) strobe_err++;
                if (store_hdr) n_store_hdr++;
                if (store_meta) n_store_meta++;
                n_in++;
                pending--;
                in_pos++;
                if (in_pos == flits) begin
                    in_pos = 0;
                    resp_idx++;
                end
            end else if (store_hdr || store_meta) begin
                strobe_err++;
            end
            if (done) begin
                got_done = 1;
                done_err_seen = done_err;
                done_cycle = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        in_val = 1'b0;
        #1;
        busy_after = busy;
        done_after = done;
        check_eq("done_seen", 64'(got_done), 64'd1);
    endtask

    task automatic check_out_seq(input string tag);
        check_eq({tag, "_out_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq({tag, "_out_flit"}, 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_num_reqs = '0; cfg_payload_bytes = '0;
        out_rdy = 1'b1; in_val = 1'b0; in_match = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outputs",
                 {busy, done, done_err, out_val, out_sel, out_idx, in_rdy, store_hdr,
                  store_meta, in_idx}, 40'd0);
        check_eq("reset_stats", {st_sent, st_rcvd, st_mism}, 48'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1 request, 100 bytes -> 2 payload flits
        do_run(1, 100, 1'b0, 1'b1, -1, 0);
        exp_q = '{{2'd0, 16'd0}, {2'd1, 16'd0}, {2'd2, 16'd0}, {2'd2, 16'd1}};
        check_out_seq("r100");
        check_eq("r100_in_cnt", 64'(n_in), 64'd4);
        check_eq("r100_store_hdr", 64'(n_store_hdr), 64'd1);
        check_eq("r100_store_meta", 64'(n_store_meta), 64'd1);
        check_eq("r100_strobe_err", 64'(strobe_err), 64'd0);
        check_eq("r100_stats", {st_sent, st_rcvd, st_mism}, {16'd1, 16'd1, 16'd0});
        check_eq("r100_done_err", 64'(done_err_seen), 64'd0);
        check_eq("r100_busy_ever", 64'(busy_ever), 64'd1);
        check_eq("r100_busy_after", 64'(busy_after), 64'd0);
        check_eq("r100_done_pulse", 64'(done_after), 64'd0);

        // 3 requests, no payload
        do_run(3, 0, 1'b0, 1'b1, -1, 0);
        exp_q = '{{2'd0, 16'd0}, {2'd1, 16'd0}, {2'd0, 16'd0}, {2'd1, 16'd0},
                  {2'd0, 16'd0}, {2'd1, 16'd0}};
        check_out_seq("p0");
        check_eq("p0_in_cnt", 64'(n_in), 64'd6);
        check_eq("p0_order_err", 64'(order_err), 64'd0);
        check_eq("p0_stats", {st_sent, st_rcvd, st_mism}, {16'd3, 16'd3, 16'd0});
        check_eq("p0_done_err", 64'(done_err_seen), 64'd0);

        // 2 requests, 64 bytes, outbound ready toggling
        do_run(2, 64, 1'b1, 1'b1, -1, 0);
        exp_q = '{{2'd0, 16'd0}, {2'd1, 16'd0}, {2'd2, 16'd0},
                  {2'd0, 16'd0}, {2'd1, 16'd0}, {2'd2, 16'd0}};
        check_out_seq("tog");
        check_eq("tog_stall_err", 64'(stall_err), 64'd0);
        check_eq("tog_stats", {st_sent, st_rcvd, st_mism}, {16'd2, 16'd2, 16'd0});

        // mismatch on payload flit 1 of request 2 (128 bytes -> 2 flits)
        do_run(2, 128, 1'b0, 1'b1, 1, 1);
        check_eq("mm_stats", {st_sent, st_rcvd, st_mism}, {16'd2, 16'd2, 16'd1});
        check_eq("mm_done_err", 64'(done_err_seen), 64'd1);

        // no response: timeout after 16 cycles in WAIT
        do_run(1, 0, 1'b0, 1'b0, -1, 0);
        check_eq("to_done_err", 64'(done_err_seen), 64'd1);
        check_eq("to_latency", 64'(done_cycle - (last_out_cyc + 1)), 64'd16);
        check_eq("to_stats", {st_sent, st_rcvd}, {16'd1, 16'd0});
        check_eq("to_busy_after", 64'(busy_after), 64'd0);
        check_eq("to_in_rdy", 64'(in_rdy), 64'd0);

        // zero requests: done next cycle, never busy
        do_run(0, 100, 1'b0, 1'b1, -1, 0);
        check_eq("z_done_cycle", 64'(done_cycle), 64'd0);
        check_eq("z_done_err", 64'(done_err_seen), 64'd0);
        check_eq("z_busy_ever", 64'(busy_ever), 64'd0);
        check_eq("z_out_cnt", 64'(n_out), 64'd0);

        // reset in the middle of DATA
        out_rdy = 1'b1;
        pulse_start(1, 200);
        for (int k = 0; k < 20 && !(out_val && out_sel == 2'd2); k++) @(negedge clk);
        check_eq("mid_reached_data", {out_val, out_sel}, {1'b1, 2'd2});
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_reset_outputs",
                 {busy, done, done_err, out_val, out_sel, out_idx, in_rdy, store_hdr,
                  store_meta, in_idx}, 40'd0);
        check_eq("mid_reset_stats", {st_sent, st_rcvd, st_mism}, 48'd0);
        rst = 1'b0;
        @(negedge clk);
        do_run(1, 100, 1'b0, 1'b1, -1, 0);
        exp_q = '{{2'd0, 16'd0}, {2'd1, 16'd0}, {2'd2, 16'd0}, {2'd2, 16'd1}};
        check_out_seq("post");
        check_eq("post_stats", {st_sent, st_rcvd, st_mism}, {16'd1, 16'd1, 16'd0});
        check_eq("post_done_err", 64'(done_err_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
